// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared command encodings, mode-register fields and helpers for the SDRAM responder
package sdram_pkg;

  // {nCS,nRAS,nCAS,nWE}; anything with nCS high is folded into NOP by the decoder
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_BST   = 4'b0110;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_LMR   = 4'b0000;

  localparam int MODE_CL_LSB = 4;
  localparam int MODE_BL_LSB = 0;
  localparam int MODE_WB_BIT = 9;
  localparam int AP_BIT      = 10;

  localparam logic [2:0] CL_2        = 3'd2;
  localparam logic [2:0] CL_3        = 3'd3;
  localparam logic [2:0] BL_CODE_MAX = 3'd3;

  typedef enum logic {BANK_IDLE, BANK_OPEN} bank_state_e;

  // BL-1 as a column mask: code 0..3 -> burst of 1/2/4/8
  function automatic logic [2:0] bl_mask(input logic [1:0] code);
    case (code)
      2'd0:    bl_mask = 3'b000;
      2'd1:    bl_mask = 3'b001;
      2'd2:    bl_mask = 3'b011;
      default: bl_mask = 3'b111;
    endcase
  endfunction

  // Sequential wrap inside the BL-aligned block; upper column bits stay fixed
  function automatic logic [8:0] burst_next(input logic [8:0] col, input logic [2:0] mask);
    logic [8:0] m;
    m = {6'b0, mask};
    burst_next = (col & ~m) | ((col + 9'd1) & m);
  endfunction

endpackage

// File: rtl/sdram_resp_mem.sv
// rtl/sdram_resp_mem.sv - backing store: one byte-enabled write port, one registered read port
module sdram_resp_mem #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [1:0]    wr_be,
  input  logic [15:0]   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [15:0]   rd_data
);

  logic [7:0] mem_lo [2**AW];
  logic [7:0] mem_hi [2**AW];

  always_ff @(posedge clk) begin
    if (wr_en && wr_be[0]) mem_lo[wr_addr] <= wr_data[7:0];
    if (wr_en && wr_be[1]) mem_hi[wr_addr] <= wr_data[15:8];
    if (rd_en) rd_data <= {mem_hi[rd_addr], mem_lo[rd_addr]};
  end

endmodule

// File: rtl/sdram_chip_responder.sv
// rtl/sdram_chip_responder.sv - SDR SDRAM device responder: command decode, bank FSMs, burst engine, CL pipe
module sdram_chip_responder
  import sdram_pkg::*;
#(
  parameter int          MEM_AW   = 16,
  parameter logic [12:0] MODE_RST = 13'h220
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sd_cke,
  input  logic        sd_ncs,
  input  logic        sd_nras,
  input  logic        sd_ncas,
  input  logic        sd_nwe,
  input  logic [1:0]  sd_ba,
  input  logic [12:0] sd_a,
  input  logic        sd_dqml,
  input  logic        sd_dqmh,
  input  logic [15:0] dq_in,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  output logic        init_done,
  output logic [15:0] refresh_cnt,
  output logic        proto_err
);

  bank_state_e bank_st [4];
  logic [12:0] row_q [4];
  logic        cl3_q, single_wr_q, pre_all_seen;
  logic [1:0]  bl_code_q;

  logic        b_active, b_wr, b_ap;
  logic [1:0]  b_ba;
  logic [8:0]  b_col;
  logic [2:0]  b_left;

  logic        v1, v2, v3;
  logic [15:0] d2, d3;
  logic [1:0]  m1, m2;

  logic [3:0]  cmd;
  logic        any_open, sel_open, rd_ok, wr_ok, new_burst, pre_hit, cont;
  logic        issue_rd, issue_wr, cl_legal, bl_legal, out_v;
  logic [1:0]  iss_ba;
  logic [8:0]  iss_col, next_col;
  logic [2:0]  cur_mask, new_len_m1;
  logic [MEM_AW-1:0] mem_addr;
  logic [15:0] rd_data, out_d;

  always_comb begin
    cmd = (sd_cke && !sd_ncs) ? {1'b0, sd_nras, sd_ncas, sd_nwe} : CMD_NOP;
    any_open = 1'b0;
    for (int i = 0; i < 4; i++) any_open = any_open | (bank_st[i] == BANK_OPEN);
    sel_open  = (bank_st[sd_ba] == BANK_OPEN);
    rd_ok     = (cmd == CMD_READ) && sel_open;
    wr_ok     = (cmd == CMD_WRITE) && sel_open;
    new_burst = rd_ok || wr_ok;
    pre_hit   = (cmd == CMD_PRE) && (sd_a[AP_BIT] || sd_ba == b_ba);
    // an accepted burst beat this edge unless something interrupts it
    cont      = b_active && sd_cke && !new_burst && (cmd != CMD_BST) && !pre_hit;
    issue_rd  = rd_ok || (cont && !b_wr);
    issue_wr  = wr_ok || (cont && b_wr);
    iss_ba    = new_burst ? sd_ba : b_ba;
    iss_col   = new_burst ? sd_a[8:0] : b_col;
    mem_addr  = MEM_AW'({iss_ba, row_q[iss_ba], iss_col});
    cur_mask  = bl_mask(bl_code_q);
    next_col  = burst_next(iss_col, cur_mask);
    new_len_m1 = (wr_ok && single_wr_q) ? 3'd0 : cur_mask;
    cl_legal  = (sd_a[MODE_CL_LSB +: 3] == CL_2) || (sd_a[MODE_CL_LSB +: 3] == CL_3);
    bl_legal  = (sd_a[MODE_BL_LSB +: 3] <= BL_CODE_MAX);
    out_v     = cl3_q ? v3 : v2;
    out_d     = cl3_q ? d3 : d2;
  end

  sdram_resp_mem #(.AW(MEM_AW)) u_mem (
    .clk    (clk),
    .wr_en  (issue_wr),
    .wr_addr(mem_addr),
    .wr_be  (~{sd_dqmh, sd_dqml}),
    .wr_data(dq_in),
    .rd_en  (issue_rd),
    .rd_addr(mem_addr),
    .rd_data(rd_data)
  );

  always_ff @(posedge clk) begin
    proto_err <= 1'b0;
    if (reset) begin
      for (int i = 0; i < 4; i++) bank_st[i] <= BANK_IDLE;
      cl3_q        <= (MODE_RST[MODE_CL_LSB +: 3] == CL_3);
      bl_code_q    <= MODE_RST[MODE_BL_LSB +: 2];
      single_wr_q  <= MODE_RST[MODE_WB_BIT];
      pre_all_seen <= 1'b0;
      init_done    <= 1'b0;
      refresh_cnt  <= 16'd0;
      b_active     <= 1'b0;
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
      m1 <= 2'b00; m2 <= 2'b00;
      dq_oe  <= 1'b0;
      dq_out <= 16'd0;
    end else if (sd_cke) begin
      case (cmd)
        CMD_ACT:
          if (sel_open) proto_err <= 1'b1;
          else begin
            bank_st[sd_ba] <= BANK_OPEN;
            row_q[sd_ba]   <= sd_a;
          end
        CMD_READ, CMD_WRITE:
          if (!sel_open) proto_err <= 1'b1;
        CMD_PRE:
          if (sd_a[AP_BIT]) begin
            for (int i = 0; i < 4; i++) bank_st[i] <= BANK_IDLE;
            pre_all_seen <= 1'b1;
          end else bank_st[sd_ba] <= BANK_IDLE;
        CMD_REF:
          if (any_open) proto_err <= 1'b1;
          else refresh_cnt <= refresh_cnt + 16'd1;
        CMD_LMR:
          if (any_open || !cl_legal || !bl_legal) proto_err <= 1'b1;
          else begin
            cl3_q       <= (sd_a[MODE_CL_LSB +: 3] == CL_3);
            bl_code_q   <= sd_a[MODE_BL_LSB +: 2];
            single_wr_q <= sd_a[MODE_WB_BIT];
            init_done   <= init_done | pre_all_seen;
          end
        default: ;
      endcase

      // auto-precharge closes the bank once its burst ends, however it ends
      if (new_burst) begin
        if (b_active && b_ap && b_ba != sd_ba) bank_st[b_ba] <= BANK_IDLE;
        b_active <= (new_len_m1 != 3'd0);
        b_wr     <= wr_ok;
        b_ba     <= sd_ba;
        b_ap     <= sd_a[AP_BIT];
        b_col    <= next_col;
        b_left   <= new_len_m1 - 3'd1;
        if (new_len_m1 == 3'd0 && sd_a[AP_BIT]) bank_st[sd_ba] <= BANK_IDLE;
      end else if (cont) begin
        if (b_left == 3'd0) begin
          b_active <= 1'b0;
          if (b_ap) bank_st[b_ba] <= BANK_IDLE;
        end else begin
          b_col  <= next_col;
          b_left <= b_left - 3'd1;
        end
      end else if (b_active) begin
        b_active <= 1'b0;
        if (b_ap) bank_st[b_ba] <= BANK_IDLE;
      end

      // read pipe: RAM register, one stage per extra CL cycle, DQM two edges behind
      v1 <= issue_rd;
      v2 <= v1;  d2 <= rd_data;
      v3 <= v2;  d3 <= d2;
      m1 <= {sd_dqmh, sd_dqml};
      m2 <= m1;
      dq_oe  <= out_v;
      dq_out <= out_v ? (out_d & ~{{8{m2[1]}}, {8{m2[0]}}}) : 16'd0;
      if (wr_ok) begin
        v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
        dq_oe  <= 1'b0;
        dq_out <= 16'd0;
      end
    end
  end

endmodule

// File: tb/tb_sdram_chip_responder.sv
// tb/tb_sdram_chip_responder.sv - directed-vector bench for the SDRAM chip responder
module tb_sdram_chip_responder;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_LMR = 4'b0000;

  logic        clk, reset, sd_cke, sd_ncs, sd_nras, sd_ncas, sd_nwe, sd_dqml, sd_dqmh;
  logic [1:0]  sd_ba;
  logic [12:0] sd_a;
  logic [15:0] dq_in, dq_out, refresh_cnt;
  logic        dq_oe, init_done, proto_err;

  int n_vec = 0;
  int n_miss = 0;

  sdram_chip_responder dut (
    .clk(clk), .reset(reset), .sd_cke(sd_cke),
    .sd_ncs(sd_ncs), .sd_nras(sd_nras), .sd_ncas(sd_ncas), .sd_nwe(sd_nwe),
    .sd_ba(sd_ba), .sd_a(sd_a), .sd_dqml(sd_dqml), .sd_dqmh(sd_dqmh),
    .dq_in(dq_in), .dq_out(dq_out), .dq_oe(dq_oe),
    .init_done(init_done), .refresh_cnt(refresh_cnt), .proto_err(proto_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_vec(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // drive pins, let the DUT sample them on the rising edge, return at the falling edge
  task automatic tick(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a,
                      input logic [15:0] d, input logic [1:0] dqm);
    {sd_ncs, sd_nras, sd_ncas, sd_nwe} = c;
    sd_ba = ba;
    sd_a  = a;
    dq_in = d;
    {sd_dqmh, sd_dqml} = dqm;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic nop();
    tick(C_NOP, 2'd0, 13'd0, 16'd0, 2'b00);
  endtask

  initial begin
    reset  = 1'b1;
    sd_cke = 1'b1;
    {sd_ncs, sd_nras, sd_ncas, sd_nwe} = C_NOP;
    sd_ba = 2'd0; sd_a = 13'd0; dq_in = 16'd0; sd_dqml = 1'b0; sd_dqmh = 1'b0;
    nop();
    nop();
    reset = 1'b0;
    check_vec("rst_dq_oe", 16'(dq_oe), 16'd0);
    check_vec("rst_dq_out", dq_out, 16'd0);
    check_vec("rst_init_done", 16'(init_done), 16'd0);
    check_vec("rst_refresh_cnt", refresh_cnt, 16'd0);
    check_vec("rst_proto_err", 16'(proto_err), 16'd0);

    // init: PRE-all then LOAD MODE 0x220 (CL2, BL1, single write)
    tick(C_PRE, 2'd0, 13'h400, 16'd0, 2'b00);
    check_vec("pre_all_err", 16'(proto_err), 16'd0);
    tick(C_LMR, 2'd0, 13'h220, 16'd0, 2'b00);
    check_vec("init_done", 16'(init_done), 16'd1);
    check_vec("lmr_err", 16'(proto_err), 16'd0);

    // write-mask and read-mask at CL2
    tick(C_ACT, 2'd1, 13'h012, 16'd0, 2'b00);
    check_vec("act_err", 16'(proto_err), 16'd0);
    tick(C_WR, 2'd1, 13'h034, 16'h1111, 2'b00);
    tick(C_WR, 2'd1, 13'h034, 16'hA5C3, 2'b01);
    tick(C_RD, 2'd1, 13'h034, 16'd0, 2'b01);
    nop();
    check_vec("cl2_n1_oe", 16'(dq_oe), 16'd0);
    nop();
    check_vec("cl2_masked_data", dq_out, 16'hA500);
    check_vec("cl2_n2_oe", 16'(dq_oe), 16'd1);
    nop();
    check_vec("cl2_n3_oe", 16'(dq_oe), 16'd0);
    tick(C_RD, 2'd1, 13'h034, 16'd0, 2'b00);
    nop();
    nop();
    check_vec("wr_byte_mask", dq_out, 16'hA511);

    // CL3 / BL8, burst write then wrapped read from col 6
    tick(C_PRE, 2'd0, 13'h400, 16'd0, 2'b00);
    tick(C_LMR, 2'd0, 13'h033, 16'd0, 2'b00);
    check_vec("lmr33_err", 16'(proto_err), 16'd0);
    tick(C_ACT, 2'd0, 13'h005, 16'd0, 2'b00);
    tick(C_WR, 2'd0, 13'h000, 16'hC000, 2'b00);
    for (int k = 1; k < 8; k++) tick(C_NOP, 2'd0, 13'd0, 16'hC000 + 16'(k), 2'b00);
    tick(C_RD, 2'd0, 13'h006, 16'd0, 2'b00);
    nop();
    nop();
    check_vec("cl3_n2_oe", 16'(dq_oe), 16'd0);
    for (int k = 0; k < 8; k++) begin
      nop();
      check_vec("bl8_wrap_data", dq_out, 16'hC000 + 16'((6 + k) % 8));
      check_vec("bl8_wrap_oe", 16'(dq_oe), 16'd1);
    end
    nop();
    check_vec("bl8_end_oe", 16'(dq_oe), 16'd0);

    // READ to another bank two edges in: seamless truncation
    tick(C_ACT, 2'd2, 13'h009, 16'd0, 2'b00);
    tick(C_WR, 2'd2, 13'h008, 16'hD000, 2'b00);
    for (int k = 1; k < 8; k++) tick(C_NOP, 2'd0, 13'd0, 16'hD000 + 16'(k), 2'b00);
    tick(C_RD, 2'd0, 13'h000, 16'd0, 2'b00);
    nop();
    tick(C_RD, 2'd2, 13'h008, 16'd0, 2'b00);
    for (int k = 0; k < 10; k++) begin
      nop();
      check_vec("rd_trunc_data", dq_out, (k < 2) ? 16'hC000 + 16'(k) : 16'hD000 + 16'(k - 2));
      check_vec("rd_trunc_oe", 16'(dq_oe), 16'd1);
    end
    nop();
    check_vec("rd_trunc_end_oe", 16'(dq_oe), 16'd0);

    // WRITE while read data is on the bus
    tick(C_RD, 2'd0, 13'h000, 16'd0, 2'b00);
    nop();
    nop();
    nop();
    check_vec("pre_cut_data", dq_out, 16'hC000);
    tick(C_WR, 2'd2, 13'h010, 16'hE000, 2'b00);
    check_vec("wr_cut_oe", 16'(dq_oe), 16'd0);
    for (int k = 1; k < 8; k++) begin
      tick(C_NOP, 2'd0, 13'd0, 16'hE000 + 16'(k), 2'b00);
      check_vec("wr_cut_pending", 16'(dq_oe), 16'd0);
    end
    tick(C_RD, 2'd2, 13'h010, 16'd0, 2'b00);
    nop();
    nop();
    nop();
    check_vec("wr_cut_stored", dq_out, 16'hE000);
    repeat (8) nop();

    // protocol violations
    tick(C_RD, 2'd1, 13'h000, 16'd0, 2'b00);
    check_vec("rd_idle_err", 16'(proto_err), 16'd1);
    nop();
    check_vec("err_pulse_len", 16'(proto_err), 16'd0);
    nop();
    nop();
    check_vec("rd_idle_no_data", 16'(dq_oe), 16'd0);
    tick(C_ACT, 2'd0, 13'h007, 16'd0, 2'b00);
    check_vec("act_open_err", 16'(proto_err), 16'd1);
    tick(C_RD, 2'd0, 13'h003, 16'd0, 2'b00);
    nop();
    nop();
    nop();
    check_vec("act_open_row_kept", dq_out, 16'hC003);
    tick(C_PRE, 2'd0, 13'h400, 16'd0, 2'b00);
    repeat (4) nop();
    tick(C_LMR, 2'd0, 13'h053, 16'd0, 2'b00);
    check_vec("lmr_cl5_err", 16'(proto_err), 16'd1);
    check_vec("lmr_cl5_init", 16'(init_done), 16'd1);

    // mode kept at CL3, then reset mid-burst
    tick(C_ACT, 2'd0, 13'h005, 16'd0, 2'b00);
    tick(C_RD, 2'd0, 13'h002, 16'd0, 2'b00);
    nop();
    nop();
    check_vec("cl_kept_n2_oe", 16'(dq_oe), 16'd0);
    nop();
    check_vec("cl_kept_data", dq_out, 16'hC002);
    reset = 1'b1;
    nop();
    reset = 1'b0;
    check_vec("rst_burst_oe", 16'(dq_oe), 16'd0);
    check_vec("rst_burst_init", 16'(init_done), 16'd0);
    tick(C_RD, 2'd0, 13'h000, 16'd0, 2'b00);
    check_vec("rst_bank_idle", 16'(proto_err), 16'd1);

    // refresh counting
    for (int k = 0; k < 300; k++) tick(C_REF, 2'd0, 13'd0, 16'd0, 2'b00);
    check_vec("refresh_300", refresh_cnt, 16'd300);
    tick(C_ACT, 2'd0, 13'h005, 16'd0, 2'b00);
    tick(C_REF, 2'd0, 13'd0, 16'd0, 2'b00);
    check_vec("ref_open_err", 16'(proto_err), 16'd1);
    check_vec("ref_open_cnt", refresh_cnt, 16'd300);
    tick(C_PRE, 2'd0, 13'h400, 16'd0, 2'b00);

    // clock suspend for three edges mid-burst
    tick(C_LMR, 2'd0, 13'h033, 16'd0, 2'b00);
    check_vec("reinit_done", 16'(init_done), 16'd1);
    tick(C_ACT, 2'd0, 13'h005, 16'd0, 2'b00);
    tick(C_RD, 2'd0, 13'h000, 16'd0, 2'b00);
    nop();
    nop();
    nop();
    check_vec("cke_first", dq_out, 16'hC000);
    sd_cke = 1'b0;
    for (int k = 0; k < 3; k++) begin
      nop();
      check_vec("cke_hold_data", dq_out, 16'hC000);
      check_vec("cke_hold_oe", 16'(dq_oe), 16'd1);
    end
    sd_cke = 1'b1;
    for (int k = 1; k < 8; k++) begin
      nop();
      check_vec("cke_resume", dq_out, 16'hC000 + 16'(k));
    end
    nop();
    check_vec("cke_end_oe", 16'(dq_oe), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
